// File: rtl/sprite_pkg.sv
// Shared sprite record type, default field widths and the little-endian unpack helper.
package sprite_pkg;

    localparam int SPRITE_ID_W      = 8;
    localparam int SPRITE_POS_W     = 16;
    localparam int SPRITE_SCALE_W   = 8;
    localparam int SPRITE_REC_BYTES = (SPRITE_ID_W + 2*SPRITE_POS_W + SPRITE_SCALE_W) / 8;

    typedef struct packed {
        logic [SPRITE_ID_W-1:0]    id;
        logic [SPRITE_POS_W-1:0]   x;
        logic [SPRITE_POS_W-1:0]   y;
        logic [SPRITE_SCALE_W-1:0] scale;
    } sprite_t;

    // Byte 0 of the stream sits in bits [7:0]; fields follow in wire order id, x, y, scale.
    function automatic sprite_t sprite_unpack(input logic [SPRITE_REC_BYTES*8-1:0] v);
        sprite_t s;
        s.id    = v[0 +: SPRITE_ID_W];
        s.x     = v[SPRITE_ID_W +: SPRITE_POS_W];
        s.y     = v[SPRITE_ID_W + SPRITE_POS_W +: SPRITE_POS_W];
        s.scale = v[SPRITE_ID_W + 2*SPRITE_POS_W +: SPRITE_SCALE_W];
        return s;
    endfunction

endpackage

// File: rtl/sprite_byte_assembler.sv
// Collects record bytes into a holding register and flags the cycle the last byte arrives.
module sprite_byte_assembler
    import sprite_pkg::*;
#(
    parameter int  ID_W    = SPRITE_ID_W,
    parameter int  POS_W   = SPRITE_POS_W,
    parameter int  SCALE_W = SPRITE_SCALE_W,
    localparam int REC_W   = ID_W + 2*POS_W + SCALE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             byte_en,
    input  logic [7:0]       byte_data,
    output logic             rec_valid,
    output logic [REC_W-1:0] rec
);

    localparam int REC_BYTES = REC_W / 8;
    localparam int IDX_W     = $clog2(REC_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REC_W-9:0] hold_q, hold_d;
    logic [REC_W-1:0] stream_vec;

    // Reorders the wire-order byte vector into packed id/x/y/scale order.
    function automatic logic [REC_W-1:0] to_fields(input logic [REC_W-1:0] v);
        return {v[0 +: ID_W],
                v[ID_W +: POS_W],
                v[ID_W + POS_W +: POS_W],
                v[ID_W + 2*POS_W +: SCALE_W]};
    endfunction

    always_comb begin
        idx_d     = idx_q;
        hold_d    = hold_q;
        rec_valid = 1'b0;
        if (rst || flush) begin
            idx_d = '0;
        end else if (byte_en) begin
            if (idx_q == LAST_IDX) begin
                idx_d     = '0;
                rec_valid = 1'b1;
            end else begin
                idx_d                 = idx_q + 1'b1;
                hold_d[idx_q*8 +: 8]  = byte_data;
            end
        end
    end

    // The final byte is taken straight from the input so the record commits on its own edge.
    assign stream_vec = {byte_data, hold_q};
    assign rec        = to_fields(stream_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

endmodule

// File: rtl/sprite_record_fifo.sv
// Sprite record FIFO: byte-stream assembly into a DEPTH-entry first-word fall-through queue.
// Optional drop counter output enabled by defining SPRITE_FIFO_DROP_CNT_EN.
module sprite_record_fifo
    import sprite_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter int  ID_W    = SPRITE_ID_W,
    parameter int  POS_W   = SPRITE_POS_W,
    parameter int  SCALE_W = SPRITE_SCALE_W,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enqueue_en,
    input  logic [7:0]         enqueue_data,
    input  logic               dequeue,
    input  logic               flush,
    output logic               is_empty,
    output logic               is_full,
    output logic [CNT_W-1:0]   count,
    output logic [ID_W-1:0]    sprite_id,
    output logic [POS_W-1:0]   sprite_x,
    output logic [POS_W-1:0]   sprite_y,
    output logic [SCALE_W-1:0] sprite_scale,
`ifdef SPRITE_FIFO_DROP_CNT_EN
    output logic [15:0]        drop_count,
`endif
    output logic               overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = ID_W + 2*POS_W + SCALE_W;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [POS_W-1:0]   x;
        logic [POS_W-1:0]   y;
        logic [SCALE_W-1:0] scale;
    } rec_t;

    rec_t             mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             rec_valid;
    logic [REC_W-1:0] rec_bits;
    rec_t             rec_in;
    rec_t             head;
    logic             empty, full, do_pop, do_push, drop;

    sprite_byte_assembler #(
        .ID_W    (ID_W),
        .POS_W   (POS_W),
        .SCALE_W (SCALE_W)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .byte_en   (enqueue_en),
        .byte_data (enqueue_data),
        .rec_valid (rec_valid),
        .rec       (rec_bits)
    );

    assign rec_in = rec_t'(rec_bits);
    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));

    // A pop on the commit edge frees the slot, so a full FIFO can still accept that record.
    assign do_pop  = dequeue && !empty && !flush && !rst;
    assign do_push = rec_valid && (!full || do_pop);
    assign drop    = rec_valid && full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (rst || flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= rec_in;
    end

    assign head         = empty ? '0 : mem_q[rd_ptr_q];
    assign is_empty     = empty;
    assign is_full      = full;
    assign count        = count_q;
    assign sprite_id    = head.id;
    assign sprite_x     = head.x;
    assign sprite_y     = head.y;
    assign sprite_scale = head.scale;
    assign overflow     = drop;

`ifdef SPRITE_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturates rather than wraps; only reset clears it.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sprite_record_fifo.sv
// Scoreboard bench for sprite_record_fifo: queue-based reference model, negedge monitor.
module tb_sprite_record_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, enqueue_en, dequeue, flush;
    logic [7:0]  enqueue_data;
    logic        is_empty, is_full, overflow;
    logic [4:0]  count;
    logic [7:0]  sprite_id, sprite_scale;
    logic [15:0] sprite_x, sprite_y;
`ifdef SPRITE_FIFO_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    always #5 clk = ~clk;

    sprite_record_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .enqueue_en   (enqueue_en),
        .enqueue_data (enqueue_data),
        .dequeue      (dequeue),
        .flush        (flush),
        .is_empty     (is_empty),
        .is_full      (is_full),
        .count        (count),
        .sprite_id    (sprite_id),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .sprite_scale (sprite_scale),
`ifdef SPRITE_FIFO_DROP_CNT_EN
        .drop_count   (drop_count),
`endif
        .overflow     (overflow)
    );

    typedef struct { int id; int x; int y; int scale; } rec_m_t;
    typedef struct { int cnt; int empty; int full; int ovf; int id; int x; int y; int scale; int drop; } exp_t;

    rec_m_t          mq[$];
    byte unsigned    pb[$];
    exp_t            exp_q[$];
    int              dropc  = 0;
    int              checks = 0;
    int              errors = 0;
    bit              chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock cycle: drive inputs, record what the outputs must show, then advance the model.
    task automatic cycle(input bit r, input bit en, input logic [7:0] d, input bit dq, input bit fl);
        exp_t   e;
        rec_m_t rm;
        bit     popped;
        int     pre;
        @(posedge clk);
        #1;
        rst = r; enqueue_en = en; enqueue_data = d; dequeue = dq; flush = fl;
        pre     = mq.size();
        e.cnt   = pre;
        e.empty = (pre == 0);
        e.full  = (pre == DEPTH);
        e.ovf   = (!r && !fl && en && pb.size() == 5 && pre == DEPTH && !dq);
        if (pre == 0) begin
            e.id = 0; e.x = 0; e.y = 0; e.scale = 0;
        end else begin
            e.id = mq[0].id; e.x = mq[0].x; e.y = mq[0].y; e.scale = mq[0].scale;
        end
        e.drop = dropc;
        if (chk_en) exp_q.push_back(e);

        if (r) begin
            mq.delete(); pb.delete(); dropc = 0;
        end else if (fl) begin
            mq.delete(); pb.delete();
        end else begin
            popped = dq && (pre > 0);
            if (popped) void'(mq.pop_front());
            if (en) begin
                pb.push_back(d);
                if (pb.size() == 6) begin
                    rm.id    = pb[0];
                    rm.x     = pb[1] + 256*pb[2];
                    rm.y     = pb[3] + 256*pb[4];
                    rm.scale = pb[5];
                    pb.delete();
                    if (pre < DEPTH || popped) mq.push_back(rm);
                    else if (dropc < 16'hFFFF) dropc++;
                end
            end
        end
    endtask

    task automatic idle();
        cycle(0, 0, 8'h00, 0, 0);
    endtask

    task automatic deq();
        cycle(0, 0, 8'h00, 1, 0);
    endtask

    // Bytes are taken from the most significant end first, matching the order they are written.
    task automatic send_rec(input logic [47:0] r, input int gap);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, r[47-8*i -: 8], 0, 0);
            for (int g = 0; g < gap; g++) idle();
        end
    endtask

    // Call right after idle(): checks the head against literal values within that idle cycle.
    task automatic expect_head(input string tag, input int id, input int x, input int y, input int sc, input int cnt);
        @(negedge clk);
        chk({tag, "_id"},    int'(sprite_id),    id);
        chk({tag, "_x"},     int'(sprite_x),     x);
        chk({tag, "_y"},     int'(sprite_y),     y);
        chk({tag, "_scale"}, int'(sprite_scale), sc);
        chk({tag, "_count"}, int'(count),        cnt);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("count",    int'(count),        e.cnt);
            chk("is_empty", int'(is_empty),     e.empty);
            chk("is_full",  int'(is_full),      e.full);
            chk("overflow", int'(overflow),     e.ovf);
            chk("id",       int'(sprite_id),    e.id);
            chk("x",        int'(sprite_x),     e.x);
            chk("y",        int'(sprite_y),     e.y);
            chk("scale",    int'(sprite_scale), e.scale);
`ifdef SPRITE_FIFO_DROP_CNT_EN
            chk("drop_count", int'(drop_count), e.drop);
`endif
        end
    end

    initial begin
        logic [47:0] r;
        rst = 1'b1; enqueue_en = 1'b0; enqueue_data = 8'h00; dequeue = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        cycle(1, 0, 8'h00, 0, 0);
        idle();

        // Scenario 1 and 2
        send_rec(48'h01_10_04_80_00_02, 0);
        idle();
        expect_head("s1", 8'h01, 16'h0410, 16'h0080, 8'h02, 1);
        send_rec(48'h02_04_04_90_00_05, 0);
        deq();
        idle();
        expect_head("s2", 8'h02, 16'h0404, 16'h0090, 8'h05, 1);
        deq();
        idle();
        expect_head("s2_empty", 0, 0, 0, 0, 0);

        // Scenario 3: fill, then one record too many
        for (int i = 0; i < DEPTH; i++) begin
            r = {i[7:0], 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            send_rec(r, 0);
        end
        send_rec(48'hAA_11_22_33_44_55, 0);
        idle();
        chk("s3_full", int'(is_full), 1);
        expect_head("s3", 0, mq[0].x, mq[0].y, mq[0].scale, DEPTH);

        // Scenario 4: commit on a full FIFO together with a dequeue
        r = 48'hBB_01_02_03_04_06;
        for (int i = 0; i < 5; i++) cycle(0, 1, r[47-8*i -: 8], 0, 0);
        cycle(0, 1, r[7:0], 1, 0);
        for (int i = 0; i < DEPTH; i++) deq();
        idle();

        // Scenario 5: partial record discarded by flush
        cycle(0, 1, 8'h55, 0, 0);
        cycle(0, 1, 8'h66, 0, 0);
        cycle(0, 1, 8'h77, 0, 0);
        cycle(0, 1, 8'h99, 0, 1);
        send_rec(48'h07_01_00_02_00_03, 0);
        idle();
        expect_head("s5", 8'h07, 1, 2, 3, 1);
        deq();

        // Scenario 6: gapped bytes, then dequeues while empty
        send_rec(48'h01_10_04_80_00_02, 2);
        idle();
        expect_head("s6", 8'h01, 16'h0410, 16'h0080, 8'h02, 1);
        deq();
        deq();
        deq();
        send_rec(48'h03_21_43_65_87_09, 0);
        idle();
        expect_head("s6_ptr", 8'h03, 16'h4321, 16'h8765, 8'h09, 1);

        // Randomized traffic: mostly filling first, then mostly draining
        for (int i = 0; i < 800; i++)
            cycle($urandom_range(199) == 0, $urandom_range(99) < 80, 8'($urandom),
                  $urandom_range(99) < 8, $urandom_range(99) == 0);
        for (int i = 0; i < 800; i++)
            cycle($urandom_range(299) == 0, $urandom_range(99) < 60, 8'($urandom),
                  $urandom_range(99) < 45, $urandom_range(99) < 2);
        for (int i = 0; i < DEPTH + 2; i++) deq();
        idle();

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
